// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared FSM encoding and default parameters for the output-port frame arbiter
package router_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_BUSY  = 2'd1,
        ARB_DRAIN = 2'd2
    } arb_state_t;

    localparam int          DEF_NUM_PORTS      = 4;
    localparam int          DEF_GAP_CYCLES     = 7;
    localparam logic [15:0] DEF_TIMEOUT_CYCLES = 16'd4096;

endpackage

// File: rtl/router_frame_arb_if.sv
// rtl/router_frame_arb_if.sv - request/grant bundle between source ports and one output arbiter
interface router_frame_arb_if
    import router_pkg::*;
#(
    parameter int NumPorts = DEF_NUM_PORTS
);
    logic [NumPorts-1:0] REQ;
    logic [NumPorts-1:0] SRC_EOF;
    logic                Q_BP;
    logic [NumPorts-1:0] GRANT;
    logic [NumPorts-1:0] HOLD;
    logic [NumPorts-1:0] SRC_BP;
    logic [NumPorts-1:0] ABORT;
    logic                BUSY;
    logic [7:0]          ABORT_CNT;

    modport master (
        output REQ, SRC_EOF, Q_BP,
        input  GRANT, HOLD, SRC_BP, ABORT, BUSY, ABORT_CNT
    );

    modport slave (
        input  REQ, SRC_EOF, Q_BP,
        output GRANT, HOLD, SRC_BP, ABORT, BUSY, ABORT_CNT
    );
endinterface

// File: rtl/router_rr_pick.sv
// rtl/router_rr_pick.sv - rotating-priority one-hot pick of the first requester at or after a pointer
module router_rr_pick #(
    parameter int NumPorts = 4,
    parameter int PtrW     = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
    input  logic [NumPorts-1:0] req,
    input  logic [PtrW-1:0]     rr_ptr,
    output logic [NumPorts-1:0] pick,
    output logic                valid
);

    // scan ports from rr_ptr upward, wrapping at NumPorts, keeping the first one set
    always_comb begin
        int idx;
        idx   = 0;
        pick  = '0;
        valid = 1'b0;
        for (int i = 0; i < NumPorts; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NumPorts) begin
                idx = idx - NumPorts;
            end
            if (!valid && req[idx[PtrW-1:0]]) begin
                pick[idx[PtrW-1:0]] = 1'b1;
                valid               = 1'b1;
            end
        end
    end

endmodule

// File: rtl/router_frame_arb.sv
// rtl/router_frame_arb.sv - frame-granular round-robin arbiter for one output port with gap and timeout
module router_frame_arb
    import router_pkg::*;
#(
    parameter int          NumPorts      = DEF_NUM_PORTS,
    parameter int          PortNo        = 1,
    parameter int          GapCycles     = DEF_GAP_CYCLES,
    parameter logic [15:0] TimeoutCycles = DEF_TIMEOUT_CYCLES
) (
    input  logic              CLK,
    input  logic              RST_N,
    router_frame_arb_if.slave arb
);

    localparam int          PtrW           = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    // the caller folds DEST==PortNo into REQ, so the number is informational here
    localparam int          unused_port_no = PortNo;
    localparam logic [15:0] TO_LAST        = TimeoutCycles - 16'd1;
    localparam logic [15:0] GAP_LAST       = 16'(GapCycles - 1);

    arb_state_t          state_q, state_d;
    logic [NumPorts-1:0] grant_q, abort_q, pick;
    logic                pick_valid;
    logic [PtrW-1:0]     rr_ptr_q, rr_ptr_nxt;
    logic [15:0]         to_cnt_q, gap_cnt_q;
    logic [7:0]          abort_cnt_q;
    logic                eof_hit, to_hit, gap_done;

    router_rr_pick #(
        .NumPorts (NumPorts),
        .PtrW     (PtrW)
    ) u_rr_pick (
        .req    (arb.REQ),
        .rr_ptr (rr_ptr_q),
        .pick   (pick),
        .valid  (pick_valid)
    );

    // pointer moves to the port just after the winner; the top port wraps to 0
    always_comb begin
        rr_ptr_nxt = '0;
        for (int i = 0; i < NumPorts - 1; i++) begin
            if (pick[i]) begin
                rr_ptr_nxt = PtrW'(i + 1);
            end
        end
    end

    // end-of-frame from the owner beats a timeout landing in the same cycle
    always_comb begin
        eof_hit  = (state_q == ARB_BUSY) && (|(arb.SRC_EOF & grant_q));
        to_hit   = (state_q == ARB_BUSY) && !eof_hit && !arb.Q_BP && (to_cnt_q == TO_LAST);
        gap_done = (gap_cnt_q == GAP_LAST);
    end

    // state register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state decode
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE:  if (pick_valid) state_d = ARB_BUSY;
            ARB_BUSY:  if (eof_hit || to_hit) state_d = (GapCycles == 0) ? ARB_IDLE : ARB_DRAIN;
            ARB_DRAIN: if (gap_done) state_d = ARB_IDLE;
            default:   state_d = ARB_IDLE;
        endcase
    end

    // grant, pointer, timeout/gap counters and abort bookkeeping
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            grant_q     <= '0;
            abort_q     <= '0;
            rr_ptr_q    <= '0;
            to_cnt_q    <= '0;
            gap_cnt_q   <= '0;
            abort_cnt_q <= '0;
        end else begin
            abort_q <= '0;
            case (state_q)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        grant_q  <= pick;
                        rr_ptr_q <= rr_ptr_nxt;
                        to_cnt_q <= '0;
                    end
                end
                ARB_BUSY: begin
                    if (eof_hit) begin
                        grant_q   <= '0;
                        gap_cnt_q <= '0;
                    end else if (to_hit) begin
                        abort_q   <= grant_q;
                        grant_q   <= '0;
                        gap_cnt_q <= '0;
                        if (abort_cnt_q != 8'hFF) begin
                            abort_cnt_q <= abort_cnt_q + 8'd1;
                        end
                    end else if (!arb.Q_BP) begin
                        to_cnt_q <= to_cnt_q + 16'd1;
                    end
                end
                ARB_DRAIN: gap_cnt_q <= gap_cnt_q + 16'd1;
                default: ;
            endcase
        end
    end

    // port-facing outputs
    always_comb begin
        arb.GRANT     = grant_q;
        arb.HOLD      = arb.REQ & ~grant_q;
        arb.SRC_BP    = arb.Q_BP ? grant_q : '0;
        arb.ABORT     = abort_q;
        arb.BUSY      = (state_q == ARB_BUSY);
        arb.ABORT_CNT = abort_cnt_q;
    end

endmodule

// File: doc/router_frame_arb.md
ROUTER_FRAME_ARB -- requirements
Module: router_frame_arb

Interface
REQ-001 Parameter NumPorts, default 4, number of source ports competing for one output port.
REQ-002 Parameter PortNo, default 1, output port number matched against DEST by the caller.
REQ-003 Parameter GapCycles, default 7, idle cycles enforced after each frame end.
REQ-004 Parameter TimeoutCycles, default 16'd4096, maximum unstalled cycles a grant is held without EOF.
REQ-005 CLK  input  1  clock; all state on rising edge.
REQ-006 RST_N  input  1  reset, asynchronous, active-low.
REQ-007 REQ  input  NumPorts  per-source SOF request for this output (SOF & DEST==PortNo).
REQ-008 SRC_EOF  input  NumPorts  per-source end-of-frame strobe.
REQ-009 Q_BP  input  1  downstream backpressure of this output.
REQ-010 GRANT  output  NumPorts  one-hot selected source, registered; all-zero when not BUSY.
REQ-011 HOLD  output  NumPorts  combinational REQ & ~GRANT; requesters asserted here SHALL stall, not collide.
REQ-012 SRC_BP  output  NumPorts  combinational Q_BP ? GRANT : 0.
REQ-013 ABORT  output  NumPorts  one-cycle one-hot pulse naming a source whose grant timed out.
REQ-014 BUSY  output  1  high while in state BUSY.
REQ-015 ABORT_CNT  output  8  saturating count of timeouts since reset.

Function
REQ-016 FSM states SHALL be IDLE, BUSY, DRAIN; encoding from the shared package.
REQ-017 IDLE: if |REQ, select first set REQ bit at or after RR_PTR (wrapping at NumPorts), load GRANT, go BUSY; GRANT visible one cycle after REQ.
REQ-018 On grant RR_PTR SHALL become (granted index + 1) mod NumPorts.
REQ-019 IDLE with REQ==0: GRANT stays 0, RR_PTR unchanged.
REQ-020 BUSY: GRANT held constant; SRC_EOF on non-granted ports SHALL be ignored.
REQ-021 BUSY: |(SRC_EOF & GRANT) SHALL clear GRANT next cycle and enter DRAIN (or IDLE when GapCycles==0).
REQ-022 BUSY: timeout counter (16 bit) SHALL reset to 0 on grant and increment each cycle with Q_BP low; Q_BP high freezes it.
REQ-023 Counter reaching TimeoutCycles-1 without EOF SHALL pulse ABORT=GRANT for one cycle, clear GRANT, increment ABORT_CNT (saturating at 255), enter DRAIN.
REQ-024 EOF and timeout in the same cycle: EOF wins; no ABORT, ABORT_CNT unchanged.
REQ-025 DRAIN: GRANT=0 for exactly GapCycles cycles, then IDLE; REQ during DRAIN SHALL be held (HOLD asserted) and served from IDLE.
REQ-026 Single-cycle frame: grant and EOF of the same source never coincide; EOF in the first BUSY cycle SHALL end the grant normally.
REQ-027 GRANT SHALL never have more than one bit set; ABORT SHALL never be set outside the timeout cycle.

Reset
REQ-028 RST_N low SHALL asynchronously force state IDLE, GRANT=0, ABORT=0, RR_PTR=0, all counters 0, BUSY=0.
REQ-029 Reset mid-frame SHALL drop the grant with no ABORT pulse; first grant after release starts search at port 0.
REQ-030 Deassertion is synchronised by the caller; block needs no internal synchroniser.

Structure
REQ-031 Shared package router_pkg SHALL hold the arb_state_t enum and default NumPorts/GapCycles/TimeoutCycles constants.
REQ-032 Rotating-priority selection SHALL be one combinational sub-module router_rr_pick (REQ, RR_PTR -> one-hot, valid).
REQ-033 Block SHALL be parameter-clean for NumPorts 2..8; no hard-coded 4-bit cases.

Verification
REQ-034 REQ=4'b0101 held, EOF 3 cycles after each grant, GapCycles=7 -> GRANT sequence 0001, 0100, 0001, grants separated by 3+7+1 cycles.
REQ-035 REQ=4'b1111 simultaneously from reset -> grants in order 0001,0010,0100,1000,0001; HOLD equals REQ&~GRANT every cycle.
REQ-036 Grant port 2, no EOF, Q_BP low, TimeoutCycles=16 -> ABORT=4'b0100 on cycle 16 after grant, ABORT_CNT=1, DRAIN entered.
REQ-037 Same as 036 with Q_BP high 10 cycles mid-frame -> ABORT delayed by exactly 10 cycles; SRC_BP=4'b0100 while Q_BP high.
REQ-038 EOF and timeout coincident on port 1 -> no ABORT, ABORT_CNT stays 0; RST_N pulsed low mid-BUSY -> GRANT=0 same cycle, next grant searches from port 0.
